dmem_access_arbiter: RTL and testbench
======================================

Name: dmem_access_arbiter

Overview:
- Sits in front of the byte-lane data memory (byte-addressed, four per-byte write enables WE0..WE3, combinational 32-bit little-endian read at A..A+3).
- Shares that memory between two requesters: port 0 is the CPU load/store path, port 1 is a debug/DMA loader. Arbitration is round-robin.
- Converts RISC-V funct3 access sizes into byte enables and load sign/zero extension. Checks alignment.
- Returns one registered response per granted request.

Parameters:
- ADDRESS_WIDTH, 17, byte-address width (matches data memory).
- DATA_WIDTH, 32, data word width. Only 32 is supported.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- REQ0, REQ1  in  1  request valid, port 0 / port 1.
- WR0, WR1  in  1  1 = store, 0 = load.
- SIZE0, SIZE1  in  3  funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- ADDR0, ADDR1  in  ADDRESS_WIDTH  byte address.
- WDATA0, WDATA1  in  DATA_WIDTH  store data, right-justified (byte in [7:0], half in [15:0]).
- GNT0, GNT1  out  1  request accepted this cycle (combinational).
- RVALID0, RVALID1  out  1  one-cycle response strobe.
- RDATA0, RDATA1  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- ERR0, ERR1  out  1  access rejected; valid only when RVALID is high.
- MEM_WE0..MEM_WE3  out  1  byte write enables to the memory.
- MEM_A  out  ADDRESS_WIDTH  memory address.
- MEM_WD  out  DATA_WIDTH  memory write data.
- MEM_RD  in  DATA_WIDTH  memory read data.

Behaviour:
- FSM has three states: IDLE -> ACCESS -> RESP -> IDLE. Every access takes exactly 3 cycles. No pipelining.
- IDLE:
  - If any REQ is high, assert GNT for exactly one port, combinationally.
  - At that edge, latch the winner's WR, SIZE, ADDR and WDATA plus a port id, and go to ACCESS.
  - If no REQ is high, stay in IDLE.
- Arbitration:
  - If only one REQ is high, that port wins.
  - If both are high, the port not granted last wins.
  - The last-grant pointer resets to "port 1", so port 0 wins the first contention.
- Requester rules:
  - Hold REQ and its fields stable until GNT is seen.
  - REQ seen while the FSM is in ACCESS or RESP is not granted; the requester keeps waiting.
  - A REQ dropped before GNT is never serviced.
- Error check, done in ACCESS on the latched fields:
  - Legal load sizes: 000, 001, 010, 100, 101. Legal store sizes: 000, 001, 010.
  - Halfword access needs ADDR[0]=0. Word access needs ADDR[1:0]=00.
  - An illegal size or a misaligned address is an error. An erroring store writes nothing.
- ACCESS:
  - MEM_A = latched ADDR. MEM_WD = latched WDATA.
  - Store byte enables: SB sets WE0 only; SH sets WE0 and WE1; SW sets WE0..WE3. The write commits at the ACCESS->RESP edge.
  - Load: MEM_RD is captured at the same edge and extended:
    - 000: sign-extend [7:0]. 100: zero-extend [7:0].
    - 001: sign-extend [15:0]. 101: zero-extend [15:0].
    - 010: pass through.
- RESP: for one cycle, the latched port's RVALID = 1 with its registered RDATA and ERR. The other port's RVALID = 0.
- Outside ACCESS, all MEM_WE = 0. MEM_A and MEM_WD keep their latched values.
- Non-responding ports hold RDATA = 0 and ERR = 0.
- Reset:
  - On reset: state = IDLE; RVALID*, ERR*, RDATA* = 0; MEM_WE* = 0; latched fields = 0.
  - All MEM_WE are gated by !RST, so no write occurs in any cycle where RST is high, including reset during ACCESS.
  - A transaction in flight when reset is applied is dropped with no RVALID.
  - GNT = 0 while RST is high.
- Addresses near the top of memory: legal aligned accesses never cross the top. No wrap handling is required.

Test Plan:
- Store then load, port 0: SW 0x8000_00FF to ADDR 0x100, then LW 0x100. Required: GNT0 in the IDLE cycle, RVALID0 two cycles later; load returns RDATA0 = 0x800000FF with ERR0 = 0.
- Extension: memory word 0x1234_80F0 at 0x200. LB 0x200 -> 0xFFFFFFF0. LBU 0x200 -> 0x000000F0. LH 0x202 -> 0x00001234. LHU 0x200 -> 0x000080F0.
- Byte lanes: SW 0xFFFFFFFF to 0x300, then SB 0xAB to 0x301, then LW 0x300. Required: 0xFFFFABFF. During the SB ACCESS cycle, MEM_WE = 0001 and MEM_A = 0x301.
- Errors: SH to 0x101, LW from 0x102, and a store with SIZE=100. Each gives ERR = 1, RDATA = 0, MEM_WE all 0; a following LW shows memory unchanged.
- Contention: REQ0 and REQ1 both held high continuously from the first cycle after reset. Grants alternate 0, 1, 0, 1, one every 3 cycles; RVALID always goes to the port that was granted.
- Reset mid-op: assert RST during the ACCESS cycle of an SW. Required: no write (a later LW returns the old value), no RVALID, FSM back in IDLE.

Source files
------------

// File: rtl/dmem_access_arbiter_if.sv
// Requester and data-memory signals of the two-port data-memory arbiter.
// The slave modport is the arbiter; the master modport is the requester/memory side.
interface dmem_access_arbiter_if #(
  parameter int ADDRESS_WIDTH = 17,
  parameter int DATA_WIDTH    = 32
);
  logic                     REQ0, REQ1;
  logic                     WR0, WR1;
  logic [2:0]               SIZE0, SIZE1;
  logic [ADDRESS_WIDTH-1:0] ADDR0, ADDR1;
  logic [DATA_WIDTH-1:0]    WDATA0, WDATA1;
  logic                     GNT0, GNT1;
  logic                     RVALID0, RVALID1;
  logic [DATA_WIDTH-1:0]    RDATA0, RDATA1;
  logic                     ERR0, ERR1;
  logic                     MEM_WE0, MEM_WE1, MEM_WE2, MEM_WE3;
  logic [ADDRESS_WIDTH-1:0] MEM_A;
  logic [DATA_WIDTH-1:0]    MEM_WD;
  logic [DATA_WIDTH-1:0]    MEM_RD;

  modport slave (
    input  REQ0, REQ1, WR0, WR1, SIZE0, SIZE1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_RD,
    output GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, ERR0, ERR1,
    output MEM_WE0, MEM_WE1, MEM_WE2, MEM_WE3, MEM_A, MEM_WD
  );

  modport master (
    output REQ0, REQ1, WR0, WR1, SIZE0, SIZE1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_RD,
    input  GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, ERR0, ERR1,
    input  MEM_WE0, MEM_WE1, MEM_WE2, MEM_WE3, MEM_A, MEM_WD
  );
endinterface

// File: rtl/dmem_access_arbiter.sv
// Round-robin two-port arbiter for the byte-lane data memory: IDLE -> ACCESS -> RESP,
// three cycles per access, funct3 size to byte-lane/extension mapping with alignment checks.
module dmem_access_arbiter #(
  parameter int ADDRESS_WIDTH = 17,
  parameter int DATA_WIDTH    = 32
) (
  input logic                 CLK,
  input logic                 RST,
  dmem_access_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t                   state;
  logic                     last_gnt;
  logic                     port_q;
  logic                     wr_q;
  logic [2:0]               size_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     rvalid0_q, rvalid1_q, err0_q, err1_q;
  logic [DATA_WIDTH-1:0]    rdata0_q, rdata1_q;

  logic                  win1, gnt0, gnt1;
  logic                  legal, aligned, err;
  logic [3:0]            lanes, mem_we;
  logic [DATA_WIDTH-1:0] load_data;

  // Port 1 wins when alone, or on contention when port 0 had the last grant.
  always_comb begin
    win1 = bus.REQ1 && (!bus.REQ0 || !last_gnt);
    gnt0 = (state == IDLE) && !RST && bus.REQ0 && !win1;
    gnt1 = (state == IDLE) && !RST && win1;
  end

  always_comb begin
    case (size_q)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !wr_q;
      default:                legal = 1'b0;
    endcase
    case (size_q[1:0])
      2'b01:   aligned = !addr_q[0];
      2'b10:   aligned = (addr_q[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    err = !(legal && aligned);
    case (size_q[1:0])
      2'b00:   lanes = 4'b0001;
      2'b01:   lanes = 4'b0011;
      default: lanes = 4'b1111;
    endcase
    mem_we = (state == ACCESS && !RST && wr_q && !err) ? lanes : 4'b0000;
    case (size_q)
      3'b000:  load_data = {{(DATA_WIDTH-8){bus.MEM_RD[7]}}, bus.MEM_RD[7:0]};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, bus.MEM_RD[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){bus.MEM_RD[15]}}, bus.MEM_RD[15:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, bus.MEM_RD[15:0]};
      default: load_data = bus.MEM_RD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      port_q    <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            port_q   <= gnt1;
            wr_q     <= gnt1 ? bus.WR1    : bus.WR0;
            size_q   <= gnt1 ? bus.SIZE1  : bus.SIZE0;
            addr_q   <= gnt1 ? bus.ADDR1  : bus.ADDR0;
            wdata_q  <= gnt1 ? bus.WDATA1 : bus.WDATA0;
            last_gnt <= gnt1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          // Stores and rejected accesses answer with zero data.
          rvalid0_q <= !port_q;
          rvalid1_q <= port_q;
          err0_q    <= !port_q && err;
          err1_q    <= port_q && err;
          rdata0_q  <= (!port_q && !err && !wr_q) ? load_data : '0;
          rdata1_q  <= (port_q && !err && !wr_q) ? load_data : '0;
          state     <= RESP;
        end
        RESP: begin
          rvalid0_q <= 1'b0;
          rvalid1_q <= 1'b0;
          err0_q    <= 1'b0;
          err1_q    <= 1'b0;
          rdata0_q  <= '0;
          rdata1_q  <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.GNT0    = gnt0;
  assign bus.GNT1    = gnt1;
  assign bus.RVALID0 = rvalid0_q;
  assign bus.RVALID1 = rvalid1_q;
  assign bus.RDATA0  = rdata0_q;
  assign bus.RDATA1  = rdata1_q;
  assign bus.ERR0    = err0_q;
  assign bus.ERR1    = err1_q;
  assign bus.MEM_WE0 = mem_we[0];
  assign bus.MEM_WE1 = mem_we[1];
  assign bus.MEM_WE2 = mem_we[2];
  assign bus.MEM_WE3 = mem_we[3];
  assign bus.MEM_A   = addr_q;
  assign bus.MEM_WD  = wdata_q;
endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: byte-array data memory, transaction-level reference model
// checked every cycle, directed literal cases and randomized two-port traffic.
module tb_dmem_access_arbiter;
  localparam int AW = 17;
  localparam int DW = 32;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  dmem_access_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  dmem_access_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  logic [7:0] mem     [0:(1<<AW)-1];
  logic [7:0] ref_mem [0:(1<<AW)-1];
  int n_vec = 0;
  int n_err = 0;

  assign bus.MEM_RD = {mem[bus.MEM_A + 17'd3], mem[bus.MEM_A + 17'd2],
                       mem[bus.MEM_A + 17'd1], mem[bus.MEM_A]};

  initial begin : memory
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    forever begin
      @(posedge CLK);
      if (bus.MEM_WE0) mem[bus.MEM_A]         <= bus.MEM_WD[7:0];
      if (bus.MEM_WE1) mem[bus.MEM_A + 17'd1] <= bus.MEM_WD[15:8];
      if (bus.MEM_WE2) mem[bus.MEM_A + 17'd2] <= bus.MEM_WD[23:16];
      if (bus.MEM_WE3) mem[bus.MEM_A + 17'd3] <= bus.MEM_WD[31:24];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic access_err(input logic wr, input logic [2:0] sz, input logic [16:0] a);
    logic ok;
    ok = wr ? (sz inside {3'd0, 3'd1, 3'd2}) : (sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (sz[1:0] == 2'd1 && a[0]) ok = 1'b0;
    if (sz[1:0] == 2'd2 && a[1:0] != 2'd0) ok = 1'b0;
    return !ok;
  endfunction

  // Reference model: a grant at cycle g means the access happens in cycle g+1, the
  // response is visible in g+2, and the arbiter can grant again from g+3.
  initial begin : model
    int cyc, gk, win, tp, nb;
    logic have, last, in_acc, in_resp, idle, twr, terr;
    logic [2:0] tsz;
    logic [16:0] ta;
    logic [31:0] twd, tres, w;
    logic [3:0] we_exp;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 8'h00;
    have = 0; last = 1; cyc = 0; gk = 0; tp = 0; twr = 0; terr = 0;
    tsz = 0; ta = 0; twd = 0; tres = 0;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      in_acc  = have && (cyc == gk + 1);
      in_resp = have && (cyc == gk + 2);
      idle    = !have || (cyc >= gk + 3);
      win = -1;
      if (!RST && idle) begin
        if (bus.REQ0 && bus.REQ1) win = last ? 0 : 1;
        else if (bus.REQ0)        win = 0;
        else if (bus.REQ1)        win = 1;
      end
      check("gnt", {30'd0, bus.GNT1, bus.GNT0}, {30'd0, win == 1, win == 0});
      nb = 1 << tsz[1:0];
      we_exp = (in_acc && !RST && twr && !terr) ? 4'((1 << nb) - 1) : 4'b0000;
      check("mem_we", {28'd0, bus.MEM_WE3, bus.MEM_WE2, bus.MEM_WE1, bus.MEM_WE0}, {28'd0, we_exp});
      if (in_acc) begin
        check("mem_a", {15'd0, bus.MEM_A}, {15'd0, ta});
        check("mem_wd", bus.MEM_WD, twd);
      end
      check("rvalid", {30'd0, bus.RVALID1, bus.RVALID0}, {30'd0, in_resp && tp == 1, in_resp && tp == 0});
      check("err", {30'd0, bus.ERR1, bus.ERR0}, {30'd0, in_resp && tp == 1 && terr, in_resp && tp == 0 && terr});
      check("rdata0", bus.RDATA0, (in_resp && tp == 0) ? tres : 32'd0);
      check("rdata1", bus.RDATA1, (in_resp && tp == 1) ? tres : 32'd0);
      if (RST) begin
        have = 0; last = 1;
      end else if (in_acc) begin
        tres = 0;
        if (!terr && twr) begin
          for (int i = 0; i < nb; i++) ref_mem[ta + 17'(i)] = twd[8*i +: 8];
        end else if (!terr) begin
          w = {ref_mem[ta + 17'd3], ref_mem[ta + 17'd2], ref_mem[ta + 17'd1], ref_mem[ta]};
          case (tsz)
            3'd0:    tres = 32'($signed(w[7:0]));
            3'd4:    tres = 32'(w[7:0]);
            3'd1:    tres = 32'($signed(w[15:0]));
            3'd5:    tres = 32'(w[15:0]);
            default: tres = w;
          endcase
        end
      end else if (win >= 0) begin
        tp  = win;
        twr = win ? bus.WR1 : bus.WR0;
        tsz = win ? bus.SIZE1 : bus.SIZE0;
        ta  = win ? bus.ADDR1 : bus.ADDR0;
        twd = win ? bus.WDATA1 : bus.WDATA0;
        terr = access_err(twr, tsz, ta);
        have = 1; gk = cyc; last = win[0];
      end
      cyc++;
    end
  end

  task automatic drive(input int p, input logic r, input logic wr, input logic [2:0] sz,
                       input logic [16:0] a, input logic [31:0] wd);
    if (p == 0) begin
      bus.REQ0 = r; bus.WR0 = wr; bus.SIZE0 = sz; bus.ADDR0 = a; bus.WDATA0 = wd;
    end else begin
      bus.REQ1 = r; bus.WR1 = wr; bus.SIZE1 = sz; bus.ADDR1 = a; bus.WDATA1 = wd;
    end
  endtask

  task automatic set_req(input int p, input logic r);
    if (p == 0) bus.REQ0 = r;
    else        bus.REQ1 = r;
  endtask

  function automatic logic gnt_of(input int p);
    return p ? bus.GNT1 : bus.GNT0;
  endfunction

  logic [31:0] seen_rd;
  logic        seen_err;
  logic [3:0]  seen_we;
  logic [16:0] seen_a;
  int          seen_wait;

  task automatic do_txn(input int p, input logic wr, input logic [2:0] sz,
                        input logic [16:0] a, input logic [31:0] wd);
    logic g;
    g = 0;
    @(posedge CLK); #1;
    drive(p, 1'b1, wr, sz, a, wd);
    seen_wait = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (gnt_of(p)) begin g = 1; break; end
      seen_wait++;
    end
    check("gnt_seen", {31'd0, g}, 32'd1);
    @(posedge CLK); #1;
    set_req(p, 1'b0);
    @(negedge CLK);
    seen_we = {bus.MEM_WE3, bus.MEM_WE2, bus.MEM_WE1, bus.MEM_WE0};
    seen_a  = bus.MEM_A;
    @(negedge CLK);
    check("rvalid_lat", {31'd0, p ? bus.RVALID1 : bus.RVALID0}, 32'd1);
    seen_rd  = p ? bus.RDATA1 : bus.RDATA0;
    seen_err = p ? bus.ERR1 : bus.ERR0;
  endtask

  task automatic xact(input string nm, input int p, input logic wr, input logic [2:0] sz,
                      input logic [16:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    do_txn(p, wr, sz, a, wd);
    check({nm, "_rdata"}, seen_rd, exp_rd);
    check({nm, "_err"}, {31'd0, seen_err}, {31'd0, exp_err});
  endtask

  task automatic rand_port(input int p);
    logic g;
    int drop_at;
    repeat (80) begin
      @(posedge CLK); #1;
      drive(p, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            17'h1000 + 17'($urandom_range(0, 31)), $urandom);
      drop_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : 99;
      g = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge CLK);
        if (gnt_of(p)) begin g = 1; break; end
        if (c == drop_at) break;
      end
      if (drop_at == 99) check("rand_gnt", {31'd0, g}, 32'd1);
      @(posedge CLK); #1;
      set_req(p, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    RST = 1'b1;
    drive(0, 1'b0, 1'b0, 3'd0, 17'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 17'd0, 32'd0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset_rvalid", {30'd0, bus.RVALID1, bus.RVALID0}, 32'd0);
    check("reset_rdata0", bus.RDATA0, 32'd0);
    check("reset_err", {30'd0, bus.ERR1, bus.ERR0}, 32'd0);

    xact("sw_100", 0, 1'b1, 3'd2, 17'h100, 32'h800000FF, 32'd0, 1'b0);
    check("sw_100_we", {28'd0, seen_we}, 32'hF);
    xact("lw_100", 0, 1'b0, 3'd2, 17'h100, 32'd0, 32'h800000FF, 1'b0);

    xact("sw_200", 0, 1'b1, 3'd2, 17'h200, 32'h123480F0, 32'd0, 1'b0);
    xact("lb_200", 0, 1'b0, 3'd0, 17'h200, 32'd0, 32'hFFFFFFF0, 1'b0);
    xact("lbu_200", 1, 1'b0, 3'd4, 17'h200, 32'd0, 32'h000000F0, 1'b0);
    xact("lh_202", 0, 1'b0, 3'd1, 17'h202, 32'd0, 32'h00001234, 1'b0);
    xact("lhu_200", 1, 1'b0, 3'd5, 17'h200, 32'd0, 32'h000080F0, 1'b0);

    xact("sw_300", 0, 1'b1, 3'd2, 17'h300, 32'hFFFFFFFF, 32'd0, 1'b0);
    xact("sb_301", 0, 1'b1, 3'd0, 17'h301, 32'h000000AB, 32'd0, 1'b0);
    check("sb_301_we", {28'd0, seen_we}, 32'h1);
    check("sb_301_a", {15'd0, seen_a}, 32'h301);
    xact("lw_300", 0, 1'b0, 3'd2, 17'h300, 32'd0, 32'hFFFFABFF, 1'b0);

    xact("sh_101", 0, 1'b1, 3'd1, 17'h101, 32'h0000DEAD, 32'd0, 1'b1);
    check("sh_101_we", {28'd0, seen_we}, 32'h0);
    xact("lw_102", 1, 1'b0, 3'd2, 17'h102, 32'd0, 32'd0, 1'b1);
    xact("st_sz4", 0, 1'b1, 3'd4, 17'h100, 32'h00000055, 32'd0, 1'b1);
    check("st_sz4_we", {28'd0, seen_we}, 32'h0);
    xact("lw_100_after_err", 0, 1'b0, 3'd2, 17'h100, 32'd0, 32'h800000FF, 1'b0);

    // Both ports request continuously from the first cycle after reset.
    @(posedge CLK); #1;
    RST = 1'b1;
    drive(0, 1'b1, 1'b0, 3'd2, 17'h100, 32'd0);
    drive(1, 1'b1, 1'b0, 3'd2, 17'h300, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      check("cont_gnt", {30'd0, bus.GNT1, bus.GNT0}, {30'd0, c % 6 == 3, c % 6 == 0});
      check("cont_rvalid", {30'd0, bus.RVALID1, bus.RVALID0}, {30'd0, c % 6 == 5, c % 6 == 2});
      if (c % 6 == 2) check("cont_rdata0", bus.RDATA0, 32'h800000FF);
      if (c % 6 == 5) check("cont_rdata1", bus.RDATA1, 32'hFFFFABFF);
    end
    @(posedge CLK); #1;
    set_req(0, 1'b0);
    set_req(1, 1'b0);

    // Reset lands on the ACCESS cycle of a store.
    xact("sw_400", 0, 1'b1, 3'd2, 17'h400, 32'h11111111, 32'd0, 1'b0);
    @(posedge CLK); #1;
    drive(0, 1'b1, 1'b1, 3'd2, 17'h400, 32'h22222222);
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (bus.GNT0) break;
    end
    check("rst_mid_gnt", {31'd0, bus.GNT0}, 32'd1);
    @(posedge CLK); #1;
    set_req(0, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_mid_we", {28'd0, bus.MEM_WE3, bus.MEM_WE2, bus.MEM_WE1, bus.MEM_WE0}, 32'd0);
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_mid_rvalid", {30'd0, bus.RVALID1, bus.RVALID0}, 32'd0);
    xact("lw_400_after_rst", 0, 1'b0, 3'd2, 17'h400, 32'd0, 32'h11111111, 1'b0);
    check("rst_mid_idle_wait", seen_wait, 32'd0);

    fork
      rand_port(0);
      rand_port(1);
    join
    repeat (5) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
